// File: rtl/piso_if.sv
// rtl/piso_if.sv - handshake bundle between a word producer, the piso converter and a slice consumer
//
// Purpose: groups the word-side and slice-side handshakes of the piso width
//          down-converter so they travel as one port.
// Signals:
//   in_valid  producer has a word on data_in
//   data_in   parallel word, DATA_IN_WIDTH bits
//   ready     converter can take a word this cycle
//   data_out  current slice, DATA_OUT_WIDTH bits
//   out_valid data_out holds a valid slice
//   out_ready consumer takes data_out this cycle
//   out_last  current slice is the most-significant slice of its word
// Modports:
//   slave  - the converter side
//   master - the side that drives words and accepts slices

interface piso_if #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16
);
  logic                      in_valid;
  logic [DATA_IN_WIDTH-1:0]  data_in;
  logic                      ready;
  logic [DATA_OUT_WIDTH-1:0] data_out;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_last;

  modport slave (
    input  in_valid,
    input  data_in,
    input  out_ready,
    output ready,
    output data_out,
    output out_valid,
    output out_last
  );

  modport master (
    output in_valid,
    output data_in,
    output out_ready,
    input  ready,
    input  data_out,
    input  out_valid,
    input  out_last
  );
endinterface

// File: rtl/piso.sv
// rtl/piso.sv - parallel-in/serial-out width down-converter with a one-word holding buffer
//
// Purpose: takes one DATA_IN_WIDTH word per valid/ready handshake and emits it as
//          NUM_SHIFTS = DATA_IN_WIDTH/DATA_OUT_WIDTH slices, least-significant first.
//          A holding buffer behind the shift register lets the next word wait so
//          slices stream at one per cycle with no gap between words.
//          DATA_IN_WIDTH must be an integer multiple of DATA_OUT_WIDTH.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    piso_if.slave: in_valid/data_in/ready word side,
//          data_out/out_valid/out_ready/out_last slice side

module piso #(
  parameter int DATA_IN_WIDTH  = 64,
  parameter int DATA_OUT_WIDTH = 16
) (
  input logic   clk,
  input logic   reset,
  piso_if.slave bus
);

  localparam int NUM_SHIFTS = DATA_IN_WIDTH / DATA_OUT_WIDTH;
  localparam int CNT_W      = $clog2(NUM_SHIFTS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SHIFTS - 1);

  // EMPTY: nothing held; BUSY: sreg holds a word; FULL: sreg and buffer both hold words.
  // The state alone encodes sreg_valid/buf_valid, so the unreachable
  // "buffer without shift register" combination cannot be represented.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                   state, state_nxt;
  logic [DATA_IN_WIDTH-1:0] sreg, sreg_nxt;
  logic [DATA_IN_WIDTH-1:0] buf_data, buf_nxt;
  logic [CNT_W-1:0]         cnt, cnt_nxt;
  logic [DATA_IN_WIDTH-1:0] sreg_shifted;

  logic sreg_valid;
  logic buf_valid;
  logic is_last;
  logic accept;
  logic xfer;
  logic xfer_last;

  assign sreg_valid = (state != EMPTY);
  assign buf_valid  = (state == FULL);
  assign is_last    = (cnt == LAST_CNT);

  // ready is forced low while reset is held so nothing is taken mid-reset.
  assign bus.ready     = !buf_valid && !reset;
  assign bus.out_valid = sreg_valid;
  assign bus.data_out  = sreg[DATA_OUT_WIDTH-1:0];
  assign bus.out_last  = sreg_valid && is_last;

  assign accept    = bus.in_valid && bus.ready;
  assign xfer      = bus.out_valid && bus.out_ready;
  assign xfer_last = xfer && is_last;

  // With a single slice per word the register never shifts, so the
  // part-select below would be empty; that case passes sreg through.
  generate
    if (NUM_SHIFTS > 1) begin : g_shift
      assign sreg_shifted = {{DATA_OUT_WIDTH{1'b0}}, sreg[DATA_IN_WIDTH-1:DATA_OUT_WIDTH]};
    end else begin : g_no_shift
      assign sreg_shifted = sreg;
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      sreg     <= '0;
      buf_data <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      sreg     <= sreg_nxt;
      buf_data <= buf_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    buf_nxt   = buf_data;
    cnt_nxt   = cnt;

    case (state)
      EMPTY: begin
        if (accept) begin
          sreg_nxt  = bus.data_in;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end
      end

      BUSY: begin
        if (xfer_last) begin
          // A word arriving on the same edge as the final slice goes straight
          // into sreg; the buffer is only used when sreg is still draining.
          cnt_nxt = '0;
          if (accept) begin
            sreg_nxt = bus.data_in;
          end else begin
            state_nxt = EMPTY;
          end
        end else begin
          if (xfer) begin
            sreg_nxt = sreg_shifted;
            cnt_nxt  = cnt + CNT_W'(1);
          end
          if (accept) begin
            buf_nxt   = bus.data_in;
            state_nxt = FULL;
          end
        end
      end

      FULL: begin
        // ready is low here, so no word can arrive; only the slice side moves.
        if (xfer_last) begin
          sreg_nxt  = buf_data;
          cnt_nxt   = '0;
          state_nxt = BUSY;
        end else if (xfer) begin
          sreg_nxt = sreg_shifted;
          cnt_nxt  = cnt + CNT_W'(1);
        end
      end

      default: begin
        state_nxt = EMPTY;
      end
    endcase
  end

endmodule

// File: tb/tb_piso.sv
// tb/tb_piso.sv - randomized self-checking bench for piso (64->16 and 16->16 instances)

module tb_piso;

  typedef struct {
    logic [15:0] d;
    bit          last;
  } slice_t;

  logic clk;
  logic reset;

  piso_if #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) bus0 ();
  piso_if #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) bus1 ();

  piso #(.DATA_IN_WIDTH(64), .DATA_OUT_WIDTH(16)) u_dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  piso #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(16)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  // Reference: a FIFO of slices still owed downstream. A word occupies the
  // converter until its last slice leaves, and at most two words fit.
  slice_t      q0[$];
  slice_t      q1[$];
  logic [63:0] sent0[$];
  logic [63:0] asm0;
  int          asm_n0;
  bit          acc0;
  bit          acc1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int words_held(input bit which);
    int n = 0;
    if (which == 1'b0) begin
      foreach (q0[i]) if (q0[i].last) n++;
    end else begin
      foreach (q1[i]) if (q1[i].last) n++;
    end
    return n;
  endfunction

  task automatic step0();
    int  words;
    bit  acc;
    bit  xf;
    words = words_held(1'b0);
    check("ready0", bus0.ready, words < 2);
    check("out_valid0", bus0.out_valid, q0.size() != 0);
    if (q0.size() != 0) begin
      check("data_out0", bus0.data_out, q0[0].d);
      check("out_last0", bus0.out_last, q0[0].last);
    end else begin
      check("out_last0_idle", bus0.out_last, 1'b0);
    end
    acc = bus0.in_valid && (words < 2);
    xf  = bus0.out_ready && (q0.size() != 0);
    if (xf) begin
      // Rebuild the word from the slices seen, as a sipo would.
      asm0 = asm0 | (64'(bus0.data_out) << (16 * asm_n0));
      asm_n0++;
      if (q0[0].last) begin
        if (sent0.size() != 0) check("loopback_word", asm0, sent0.pop_front());
        asm0   = '0;
        asm_n0 = 0;
      end
      void'(q0.pop_front());
    end
    if (acc) begin
      for (int k = 0; k < 4; k++) q0.push_back(slice_t'{bus0.data_in[16*k +: 16], k == 3});
      sent0.push_back(bus0.data_in);
    end
    acc0 = acc;
  endtask

  task automatic step1();
    int  words;
    bit  acc;
    bit  xf;
    words = words_held(1'b1);
    check("ready1", bus1.ready, words < 2);
    check("out_valid1", bus1.out_valid, q1.size() != 0);
    check("out_last1", bus1.out_last, q1.size() != 0);
    if (q1.size() != 0) check("data_out1", bus1.data_out, q1[0].d);
    acc = bus1.in_valid && (words < 2);
    xf  = bus1.out_ready && (q1.size() != 0);
    if (xf) void'(q1.pop_front());
    if (acc) q1.push_back(slice_t'{bus1.data_in, 1'b1});
    acc1 = acc;
  endtask

  // Drive one cycle of stimulus, check both instances, advance past the edge.
  task automatic tick(input bit iv0, input logic [63:0] d0, input bit or0,
                      input bit iv1, input logic [15:0] d1, input bit or1);
    bus0.in_valid  = iv0;
    bus0.data_in   = d0;
    bus0.out_ready = or0;
    bus1.in_valid  = iv1;
    bus1.data_in   = d1;
    bus1.out_ready = or1;
    #1;
    step0();
    step1();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    sent0.delete();
    asm0   = '0;
    asm_n0 = 0;
  endtask

  logic [63:0] wd [2];
  logic [15:0] exp_s [4];
  bit          bp [8];
  int          idx;
  int          nslices;

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_model();
    reset          = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.data_in   = '0;
    bus0.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.data_in   = '0;
    bus1.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus0.out_valid, 1'b0);
    check("rst_out_last", bus0.out_last, 1'b0);
    check("rst_data_out", bus0.data_out, 16'h0);
    check("rst_ready", bus0.ready, 1'b0);
    check("rst_ready1", bus1.ready, 1'b0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", bus0.ready, 1'b1);
    check("post_rst_ready1", bus1.ready, 1'b1);

    // Single word, slices 0x1111..0x4444 in the four cycles after acceptance.
    exp_s[0] = 16'h1111; exp_s[1] = 16'h2222; exp_s[2] = 16'h3333; exp_s[3] = 16'h4444;
    tick(1'b1, 64'h4444_3333_2222_1111, 1'b1, 1'b0, 16'h0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      check("single_valid", bus0.out_valid, 1'b1);
      check("single_data", bus0.data_out, exp_s[k]);
      check("single_last", bus0.out_last, k == 3);
      tick(1'b0, 64'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    end
    check("single_done", bus0.out_valid, 1'b0);

    // Back-to-back words with in_valid and out_ready held high.
    wd[0] = 64'hAAAA_AAAA_AAAA_AAAA;
    wd[1] = 64'hBBBB_BBBB_BBBB_BBBB;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      if (c >= 1 && c <= 8) begin
        check("b2b_valid", bus0.out_valid, 1'b1);
        check("b2b_last", bus0.out_last, (c == 4) || (c == 8));
      end
      if (c >= 2 && c <= 4) check("b2b_full_ready", bus0.ready, 1'b0);
      tick(idx < 2, (idx < 2) ? wd[idx] : 64'h0, 1'b1, 1'b0, 16'h0, 1'b1);
      if (acc0) idx++;
    end
    check("b2b_words", idx, 2);

    // Backpressure: out_ready 1,0,0,1 then high; four slices in total.
    bp[0] = 1; bp[1] = 0; bp[2] = 0; bp[3] = 1; bp[4] = 1; bp[5] = 1; bp[6] = 1; bp[7] = 1;
    tick(1'b1, 64'h0000_C0DE_0000_0000, 1'b1, 1'b0, 16'h0, 1'b1);
    nslices = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus0.out_valid && bp[k]) nslices++;
      tick(1'b0, 64'h0, bp[k], 1'b0, 16'h0, 1'b1);
    end
    check("bp_slice_count", nslices, 4);

    // Reset after two slices of a word, with the buffer holding the next one.
    tick(1'b1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0, 16'h0, 1'b1);
    tick(1'b1, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 16'h0, 1'b1);
    tick(1'b0, 64'h0, 1'b1, 1'b0, 16'h0, 1'b1);
    check("pre_rst_full", bus0.ready, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_out_valid", bus0.out_valid, 1'b0);
    check("mid_rst_ready", bus0.ready, 1'b0);
    check("mid_rst_out_last", bus0.out_last, 1'b0);
    clear_model();
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("after_rst_ready", bus0.ready, 1'b1);
    check("after_rst_out_valid", bus0.out_valid, 1'b0);
    tick(1'b1, 64'h0D0C_0B0A_0302_0100, 1'b1, 1'b0, 16'h0, 1'b1);
    check("after_rst_slice0", bus0.data_out, 16'h0100);
    for (int k = 0; k < 5; k++) tick(1'b0, 64'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Single-slice instance: stream 1..5 under random out_ready.
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      check("ns1_last_eq_valid", bus1.out_last, bus1.out_valid);
      tick(1'b0, 64'h0, 1'b1, idx < 5, 16'(idx + 1), 1'($urandom_range(0, 1)));
      if (acc1) idx++;
    end
    check("ns1_words", idx, 5);
    for (int k = 0; k < 4; k++) tick(1'b0, 64'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    // Random traffic on both instances, including zero words.
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] rw;
      rw = ($urandom_range(0, 15) == 0) ? 64'h0 : {$urandom, $urandom};
      tick(1'($urandom_range(0, 1)), rw, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int k = 0; k < 12; k++) tick(1'b0, 64'h0, 1'b1, 1'b0, 16'h0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/piso.md
# piso

Parallel-in/serial-out width down-converter: accepts one DATA_IN_WIDTH word with a valid/ready handshake and emits it as NUM_SHIFTS = DATA_IN_WIDTH/DATA_OUT_WIDTH narrower slices, least-significant slice first. It is the transmit-side counterpart of the sipo collector: a sipo fed by this block's slices reconstructs the original word bit-exactly. A one-word holding buffer behind the shift register gives sustained throughput of one slice per cycle with no bubble between words.

## Interface
- DATA_IN_WIDTH, 64, parallel input word width; must be an integer multiple of DATA_OUT_WIDTH.
- DATA_OUT_WIDTH, 16, serial slice width.
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  data_in holds a word to transfer.
- data_in  input  DATA_IN_WIDTH  parallel word.
- ready  output  1  block can accept a word this cycle.
- data_out  output  DATA_OUT_WIDTH  current slice.
- out_valid  output  1  data_out holds a valid slice.
- out_ready  input  1  downstream accepts data_out this cycle.
- out_last  output  1  current slice is the final (most-significant) slice of its word.

## Operation
- Word accepted on any rising edge with in_valid && ready; slice transferred on any rising edge with out_valid && out_ready.
- Storage: shift register (sreg, DATA_IN_WIDTH), slice counter (cnt, width C_LOG_2(NUM_SHIFTS)+1, range 0..NUM_SHIFTS-1), sreg_valid; holding buffer (buf, DATA_IN_WIDTH) with buf_valid.
- States: EMPTY (!sreg_valid, !buf_valid), BUSY (sreg_valid, !buf_valid), FULL (sreg_valid, buf_valid). !sreg_valid && buf_valid is unreachable.
- ready = !buf_valid && !reset (high in EMPTY and BUSY, low in FULL and while reset is asserted).
- data_out = sreg[DATA_OUT_WIDTH-1:0]; out_valid = sreg_valid; out_last = sreg_valid && (cnt == NUM_SHIFTS-1).
- Slice transfer, not last: sreg shifts right by DATA_OUT_WIDTH (zero fill at top); cnt increments.
- Slice transfer, last: cnt returns to 0. sreg reloads from buf if buf_valid, otherwise from data_in if a word is accepted the same edge; otherwise sreg_valid clears.
- Accept in EMPTY: data_in loads sreg directly; cnt = 0; sreg_valid = 1.
- Accept in BUSY with no last-slice transfer on the same edge: data_in loads buf; buf_valid = 1.
- Accept in BUSY coinciding with a last-slice transfer: data_in loads sreg directly; buf stays empty.
- FULL with last-slice transfer: buf moves to sreg; buf_valid clears; ready rises the next cycle.
- NUM_SHIFTS == 1: no shifting; every slice is last, out_last = out_valid; the block behaves as a 2-deep register FIFO.
- The data path does not depend on the data value; zero words are transferred like any other.

## Timing
- Reset (asynchronous, immediate): sreg, buf, cnt = 0; sreg_valid, buf_valid = 0; so out_valid = 0, out_last = 0, data_out = 0, ready = 0 while asserted. ready = 1 in the first cycle after deassertion.
- Latency: a word accepted at edge N presents slice 0 with out_valid high in cycle N+1 (from EMPTY).
- Throughput: with out_ready held high and in_valid held high, out_valid stays continuously high and ready pulses once every NUM_SHIFTS cycles (steady state).
- out_valid and data_out hold stable while out_ready is low; no slice is dropped or duplicated.
- Reset mid-word discards sreg and buf contents; no partial word resumes after reset.
- in_valid while ready is low has no effect; the upstream holds data_in.

## Test plan
- Single word, IN=64/OUT=16, data_in=0x4444_3333_2222_1111, out_ready=1 -> data_out 0x1111, 0x2222, 0x3333, 0x4444 in cycles N+1..N+4; out_last only with 0x4444; out_valid low in N+5.
- Back-to-back words 0xA..A, 0xB..B with in_valid and out_ready held high -> 8 consecutive valid slices with no gap; ready low while FULL; out_last in cycles N+4 and N+8.
- Backpressure: out_ready toggled 1,0,0,1 during a word -> each slice held stable while stalled, then presented in order; total slice count 4.
- Loop-back into sipo (same parameters) with random words and random out_ready -> the sipo out_valid pulses once per word and its data_out equals the original word.
- Reset asserted after 2 slices of a word with buf full -> out_valid and ready drop immediately; after release ready=1, out_valid=0; the next word starts at slice 0.
- NUM_SHIFTS=1 (IN=OUT=16), stream 0x0001..0x0005 with random out_ready -> values emitted in order, out_last equals out_valid.
